// File: rtl/jk_pkg.sv
// Shared types and the per-bit JK excitation rule for the JK bank write driver.
package jk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StWait
  } state_e;

  localparam logic [1:0] JkHold   = 2'b00;
  localparam logic [1:0] JkReset  = 2'b01;
  localparam logic [1:0] JkSet    = 2'b10;
  localparam logic [1:0] JkToggle = 2'b11;

  // Returns {j, k} that moves a flop currently at q to target t.
  function automatic logic [1:0] jk_excite(input logic t, input logic q);
    if (t == q) begin
      return JkHold;
    end
    return t ? JkSet : JkReset;
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Request/response and flop-bank signals between a caller, the JK driver and the bank.
interface jk_excite_driver_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_target;
  logic [WIDTH-1:0]  j;
  logic [WIDTH-1:0]  k;
  logic [WIDTH-1:0]  q_fb;
  logic              busy;
  logic              done;
  logic              err;
  logic [RetryW-1:0] retries;

  modport master (
    output in_valid, in_target, q_fb,
    input  in_ready, j, k, busy, done, err, retries
  );

  modport slave (
    input  in_valid, in_target, q_fb,
    output in_ready, j, k, busy, done, err, retries
  );

endinterface

// File: rtl/jk_excite_bit.sv
// One-bit JK excitation: picks hold/set/reset so the flop lands on its target.
module jk_excite_bit
  import jk_pkg::*;
(
    input  logic t_i,
    input  logic q_i,
    output logic j_o,
    output logic k_o
);

  logic [1:0] code;

  always_comb begin
    code = jk_excite(t_i, q_i);
    // A toggle would flip a flop on every DRIVE, so it is never let through.
    if (code == JkToggle) begin
      code = JkHold;
    end
  end

  assign {j_o, k_o} = code;

endmodule

// File: rtl/jk_excite_driver.sv
// Write-side driver for a JK flop bank: one excitation pulse, settle, read back, retry.
module jk_excite_driver
  import jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input logic               clk,
    input logic               reset_n,
    jk_excite_driver_if.slave bus
);

  localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state_q;
  logic [WIDTH-1:0]  target_q;
  logic [WIDTH-1:0]  j_q;
  logic [WIDTH-1:0]  k_q;
  logic [CntW-1:0]   cnt_q;
  logic [RetryW-1:0] retries_q;
  logic              done_q;
  logic              err_q;

  logic [WIDTH-1:0]  exc_t;
  logic [WIDTH-1:0]  exc_j;
  logic [WIDTH-1:0]  exc_k;

  // Fresh target on accept, held target on a retry re-drive.
  assign exc_t = (state_q == StIdle) ? bus.in_target : target_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite_bit u_bit (
      .t_i (exc_t[i]),
      .q_i (bus.q_fb[i]),
      .j_o (exc_j[i]),
      .k_o (exc_k[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      target_q  <= '0;
      j_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      retries_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            target_q  <= bus.in_target;
            retries_q <= '0;
            j_q       <= exc_j;
            k_q       <= exc_k;
            state_q   <= StDrive;
          end
        end
        StDrive: begin
          j_q     <= '0;
          k_q     <= '0;
          cnt_q   <= CntW'(SETTLE - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (bus.q_fb == target_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (retries_q < RetryW'(MAX_RETRY)) begin
            retries_q <= retries_q + RetryW'(1);
            j_q       <= exc_j;
            k_q       <= exc_k;
            state_q   <= StDrive;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.j        = j_q;
  assign bus.k        = k_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.retries  = retries_q;

endmodule
